bcd_scan_driver: RTL

- Upstream feeder for the BCD-to-seven-segment decoder.
- Accepts a packed multi-digit BCD word over a valid/ready handshake and double-buffers it.
- Time-multiplexes one digit at a time onto the decoder's 4-bit input, with a one-hot active-high digit select for a common-cathode/anode multiplexed display.
- Inserts guard (all-off) slots between digits to prevent ghosting, and swaps in new data only at frame boundaries, so no frame mixes old and new digits.

---
 rtl/bcd_scan_driver.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver
//   Upstream feeder for a BCD-to-seven-segment decoder. Accepts a packed
//   multi-digit BCD word over valid/ready and double-buffers it. It drives one
//   digit at a time with a one-hot digit select, inserts dark guard slots
//   between digits, and swaps in new data only at frame boundaries.
//   Optional feature macro: BCD_SCAN_LEADING_ZERO_BLANK_EN (blank leading zeros).
module bcd_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 1000,
    parameter int GUARD      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [4*NUM_DIGITS-1:0]       load_data,
    output logic [3:0]                    digit_bcd,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done,
    output logic                          err_bcd
);

    localparam int DATA_W  = 4 * NUM_DIGITS;
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (PRESCALE > GUARD) ? PRESCALE : GUARD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(PRESCALE - 1);
    // With GUARD=0 the guard state is never entered, so this value is unused.
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_GUARD
    } state_t;

    // Per-digit "may light" mask, computed once whenever the active buffer is
    // written: invalid nibbles are always dark, leading zeros optionally so.
    function automatic logic [NUM_DIGITS-1:0] show_mask(input logic [DATA_W-1:0] word);
        logic [NUM_DIGITS-1:0] mask;
        logic                  lit;
        mask = '0;
        lit  = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
            lit = lit | (word[4*k +: 4] != 4'd0) | (k == 0);
`else
            lit = 1'b1;
`endif
            mask[k] = lit & (word[4*k +: 4] <= 4'd9);
        end
        return mask;
    endfunction

    function automatic logic has_invalid(input logic [DATA_W-1:0] word);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            bad = bad | (word[4*k +: 4] > 4'd9);
        end
        return bad;
    endfunction

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [NUM_DIGITS-1:0] sel_q;
    logic [3:0]            bcd_q;
    logic                  frame_done_q;
    logic                  err_q;
    logic                  ready_q;
    logic [DATA_W-1:0]     active_q;
    logic [DATA_W-1:0]     shadow_q;
    logic                  shadow_full_q;
    logic [NUM_DIGITS-1:0] mask_q;

    logic                  accept;
    logic                  scan_end;
    logic                  guard_end;
    logic                  advance;
    logic                  wrap;
    logic                  swap;
    logic [IDX_W-1:0]      next_idx;
    logic [DATA_W-1:0]     next_active;
    logic [NUM_DIGITS-1:0] next_mask;
    logic [NUM_DIGITS-1:0] load_mask;
    logic                  shadow_full_d;

    // Slot sequencing decisions and the values the next digit slot will show.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        accept        = load_valid & ready_q;
        scan_end      = 1'b0;
        guard_end     = 1'b0;
        advance       = 1'b0;
        wrap          = 1'b0;
        swap          = 1'b0;
        next_idx      = idx_q + IDX_W'(1);
        next_active   = active_q;
        next_mask     = mask_q;
        load_mask     = show_mask(load_data);
        shadow_full_d = shadow_full_q;

        scan_end  = (state_q == S_SCAN)  && (cnt_q == SCAN_LAST);
        guard_end = (state_q == S_GUARD) && (cnt_q == GUARD_LAST);
        advance   = (scan_end && (GUARD == 0)) || guard_end;
        wrap      = advance && (idx_q == LAST_IDX);
        swap      = wrap && shadow_full_q;

        if (wrap) begin
            next_idx = '0;
        end
        if (swap) begin
            next_active = shadow_q;
            next_mask   = show_mask(shadow_q);
        end

        // Shadow empties on a swap; otherwise it fills on any load accepted
        // outside IDLE (a swap and an accept cannot coincide: ready is low).
        if (swap) begin
            shadow_full_d = 1'b0;
        end else if (accept && (state_q != S_IDLE)) begin
            shadow_full_d = 1'b1;
        end
    end

    // Scan FSM with registered outputs, buffers and handshake state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the data buffers are ordinary registers, not a RAM, and are
            // cleared here so a mid-frame reset discards all data in flight.
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            sel_q         <= '0;
            bcd_q         <= '0;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
            ready_q       <= 1'b1;
            active_q      <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            mask_q        <= '0;
        end else begin
            frame_done_q  <= 1'b0;
            shadow_full_q <= shadow_full_d;
            ready_q       <= ~shadow_full_d;

            if (accept && has_invalid(load_data)) begin
                err_q <= 1'b1;
            end
            if (accept && (state_q != S_IDLE)) begin
                shadow_q <= load_data;
            end

            case (state_q)
                S_IDLE: begin
                    sel_q <= '0;
                    if (accept) begin
                        active_q <= load_data;
                        mask_q   <= load_mask;
                        state_q  <= S_SCAN;
                        cnt_q    <= '0;
                        idx_q    <= '0;
                        bcd_q    <= load_data[3:0];
                        sel_q    <= load_mask[0] ? NUM_DIGITS'(1) : '0;
                    end
                end

                S_SCAN, S_GUARD: begin
                    if (advance) begin
                        state_q  <= S_SCAN;
                        cnt_q    <= '0;
                        idx_q    <= next_idx;
                        bcd_q    <= next_active[4*next_idx +: 4];
                        sel_q    <= next_mask[next_idx] ? (NUM_DIGITS'(1) << next_idx) : '0;
                        active_q <= next_active;
                        mask_q   <= next_mask;
                        if (wrap) begin
                            frame_done_q <= 1'b1;
                        end
                    end else if (scan_end) begin
                        // Only reachable with GUARD>0: go dark, hold bcd/idx.
                        state_q <= S_GUARD;
                        cnt_q   <= '0;
                        sel_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign load_ready = ready_q;
    assign digit_bcd  = bcd_q;
    assign digit_sel  = sel_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;
    assign err_bcd    = err_q;

endmodule
